// File: rtl/writeback.sv
// Y86-64 writeback stage: W pipeline register, register-file write ports,
// architectural status, halt freeze and cycle/retire counters.
module writeback (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  M_stat,
    input  logic [3:0]  m_stat,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic        W_stall,
    output logic [3:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  Stat,
    output logic        halted,
    output logic [63:0] cycle_count,
    output logic [63:0] retired_count
);

    localparam logic [3:0] STAT_BUB = 4'h0;
    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    typedef enum logic {
        RUN,
        HALTED
    } wb_state_e;

    wb_state_e state_q;
    wb_state_e state_d;
    logic      load;

    // The captured status comes from m_stat (memory check applied); M_stat is
    // accepted only so the port list matches the M register.
    logic unused_m_stat;
    assign unused_m_stat = ^M_stat;

    function automatic logic is_exception(input logic [3:0] s);
        return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            RUN: begin
                load = !W_stall;
                if (load && is_exception(m_stat)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            W_stat  <= STAT_BUB;
            W_icode <= ICODE_NOP;
            W_dstE  <= REG_NONE;
            W_dstM  <= REG_NONE;
            W_valE  <= '0;
            W_valM  <= '0;
        end else if (load) begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            // A faulting instruction must never reach the register file.
            if (m_stat == STAT_AOK) begin
                W_dstE <= M_dstE;
                W_dstM <= M_dstM;
            end else begin
                W_dstE <= REG_NONE;
                W_dstM <= REG_NONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (state_q == RUN) begin
                cycle_count <= cycle_count + 64'd1;
            end
            if (load && (m_stat == STAT_AOK)) begin
                retired_count <= retired_count + 64'd1;
            end
        end
    end

    assign halted = is_exception(W_stat);
    assign Stat   = (W_stat == STAT_BUB) ? STAT_AOK : W_stat;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: stimulus pushes expected W state into a
// queue, a monitor pops and compares one entry per loaded clock edge.
module tb_writeback;

    logic        clock;
    logic        reset;
    logic [3:0]  M_stat, m_stat, M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic        W_stall;
    logic [3:0]  W_stat, W_icode, W_dstE, W_dstM, Stat;
    logic [63:0] W_valE, W_valM, cycle_count, retired_count;
    logic        halted;

    writeback dut (
        .clock(clock), .reset(reset),
        .M_stat(M_stat), .m_stat(m_stat), .M_icode(M_icode),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
        .W_stall(W_stall),
        .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_valE(W_valE), .W_valM(W_valM), .Stat(Stat), .halted(halted),
        .cycle_count(cycle_count), .retired_count(retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  stat, icode, dste, dstm, sstat;
        logic [63:0] vale, valm, cyc, ret;
        logic        hlt;
    } exp_t;

    exp_t sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Architectural model of the W stage
    logic [3:0]  mod_stat, mod_icode, mod_dste, mod_dstm;
    logic [63:0] mod_vale, mod_valm, mod_cyc, mod_ret;
    logic        mod_halted;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input exp_t e);
        check("W_stat", {60'd0, W_stat}, {60'd0, e.stat});
        check("W_icode", {60'd0, W_icode}, {60'd0, e.icode});
        check("W_dstE", {60'd0, W_dstE}, {60'd0, e.dste});
        check("W_dstM", {60'd0, W_dstM}, {60'd0, e.dstm});
        check("W_valE", W_valE, e.vale);
        check("W_valM", W_valM, e.valm);
        check("Stat", {60'd0, Stat}, {60'd0, e.sstat});
        check("halted", {63'd0, halted}, {63'd0, e.hlt});
        check("cycle_count", cycle_count, e.cyc);
        check("retired_count", retired_count, e.ret);
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.stat  = mod_stat;
        e.icode = mod_icode;
        e.dste  = mod_dste;
        e.dstm  = mod_dstm;
        e.vale  = mod_vale;
        e.valm  = mod_valm;
        e.cyc   = mod_cyc;
        e.ret   = mod_ret;
        e.hlt   = mod_halted;
        e.sstat = (mod_stat == 4'd0) ? 4'd1 : mod_stat;
        return e;
    endfunction

    task automatic model_reset();
        mod_stat   = 4'd0;
        mod_icode  = 4'd1;
        mod_dste   = 4'hF;
        mod_dstm   = 4'hF;
        mod_vale   = '0;
        mod_valm   = '0;
        mod_cyc    = '0;
        mod_ret    = '0;
        mod_halted = 1'b0;
    endtask

    // Called at a falling edge: drives M, predicts W after the next rising edge.
    task automatic drive(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] de,
                         input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm,
                         input logic stall);
        m_stat  = st;
        // Upstream only ever downgrades AOK to ADR; M_stat is the pre-check value.
        M_stat  = (st == 4'd3 && $urandom_range(0, 1) == 1) ? 4'd1 : st;
        M_icode = ic;
        M_dstE  = de;
        M_dstM  = dm;
        M_valE  = ve;
        m_valM  = vm;
        W_stall = stall;
        if (!mod_halted) begin
            mod_cyc = mod_cyc + 64'd1;
            if (!stall) begin
                mod_stat  = st;
                mod_icode = ic;
                mod_vale  = ve;
                mod_valm  = vm;
                mod_dste  = (st == 4'd1) ? de : 4'hF;
                mod_dstm  = (st == 4'd1) ? dm : 4'hF;
                if (st == 4'd1) mod_ret = mod_ret + 64'd1;
            end
        end
        mod_halted = (mod_stat >= 4'd2) && (mod_stat <= 4'd4);
        sb.push_back(snapshot());
        @(negedge clock);
    endtask

    // Asserts reset between edges and checks the asynchronous clear at once.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all(snapshot());
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic rand_cycle();
        int unsigned r;
        logic [3:0] st;
        r = $urandom_range(0, 99);
        if (r < 70)      st = 4'd1;
        else if (r < 82) st = 4'd0;
        else if (r < 88) st = 4'd2;
        else if (r < 94) st = 4'd3;
        else             st = 4'd4;
        drive(st, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3) == 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare_all(e);
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        {M_stat, m_stat, M_icode, M_dstE, M_dstM} = '0;
        M_valE = '0; m_valM = '0; W_stall = 1'b0;
        model_reset();
        @(negedge clock);
        pulse_reset();

        // Simple AOK load
        drive(4'd1, 4'd6, 4'd3, 4'hF, 64'h2A, 64'h0, 1'b0);
        // Stall for three edges while M changes
        for (int i = 0; i < 3; i++)
            drive(4'd1, 4'd3, 4'(i + 7), 4'(i), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        // ADR on mrmovq, then the freeze
        drive(4'd3, 4'd5, 4'hF, 4'd5, 64'h10, 64'hFF, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(4'd1, 4'd6, 4'd2, 4'd4, 64'h55, 64'h66, i == 1);
        pulse_reset();
        // Halt, then the freeze and a reset mid-cycle
        drive(4'd1, 4'd2, 4'hF, 4'd7, 64'h8, 64'h99, 1'b0);
        drive(4'd2, 4'd0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
        drive(4'd1, 4'd6, 4'd1, 4'hF, 64'h3, 64'h0, 1'b0);
        pulse_reset();
        // Stall coinciding with an exception: captured on the first free edge
        drive(4'd4, 4'd13, 4'd1, 4'd2, 64'h1, 64'h2, 1'b1);
        drive(4'd4, 4'd13, 4'd1, 4'd2, 64'h1, 64'h2, 1'b0);
        pulse_reset();
        // Bubble
        drive(4'd0, 4'd1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
        // Retire counter wrap through a backdoor preload
        force dut.retired_count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.retired_count;
        mod_ret = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(4'd1, 4'd6, 4'd9, 4'hF, 64'h77, 64'h0, 1'b0);
        drive(4'd0, 4'd1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);

        // Randomised traffic, resetting occasionally once halted
        for (int i = 0; i < 400; i++) begin
            if (mod_halted && $urandom_range(0, 3) == 0) pulse_reset();
            else rand_cycle();
        end

        repeat (3) @(negedge clock);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback.md
# writeback

Final stage of the five-stage pipelined Y86-64 processor. Holds the W pipeline register, captured from the memory stage each cycle. Drives the register-file write port and the W-stage forwarding sources consumed by decode: W_dstE, W_dstM, W_valE, W_valM. Also owns the architectural processor status, the halt freeze, and the cycle and retired-instruction counters.

## Interface
Parameters:
- none; widths fixed by the Y86-64 ISA (4-bit codes, 64-bit data).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- M_stat  in  4  status carried in the M register.
- m_stat  in  4  memory-stage status after data-memory check (ADR override applied upstream).
- M_icode  in  4  instruction code in M.
- M_dstE  in  4  E-destination register ID in M.
- M_dstM  in  4  M-destination register ID in M.
- M_valE  in  64  ALU result in M.
- m_valM  in  64  data read by the memory stage.
- W_stall  in  1  hold request from pipeline control.
- W_stat  out  4  status of the instruction in W.
- W_icode  out  4  instruction code in W.
- W_dstE  out  4  register-file write port E address (F = no write).
- W_dstM  out  4  register-file write port M address (F = no write).
- W_valE  out  64  write data for port E.
- W_valM  out  64  write data for port M.
- Stat  out  4  architectural processor status.
- halted  out  1  high while W holds HLT, ADR or INS.
- cycle_count  out  64  cycles elapsed since reset while not halted.
- retired_count  out  64  instructions retired with AOK status.

## Operation
- Status codes: BUB=0, AOK=1, HLT=2, ADR=3, INS=4. Nop icode=1. No-register ID=F.
- Reset values: W_stat=0 (BUB), W_icode=1, W_dstE=W_dstM=F, W_valE=W_valM=0, Stat=1, halted=0, both counters 0.
- Load condition: load = !W_stall && !halted.
- On load:
  - W_stat<=m_stat, W_icode<=M_icode, W_valE<=M_valE, W_valM<=m_valM.
  - If m_stat==AOK: W_dstE<=M_dstE, W_dstM<=M_dstM. Otherwise both are forced to F, so a faulting instruction never writes the register file.
- When load is false, every W field holds its value.
- halted is combinational: W_stat is 2, 3 or 4. While halted, the W register is frozen regardless of W_stall until reset. This is the two-state machine RUN -> HALTED. Entry is a load with m_stat in {2,3,4}. The only exit is reset.
- Stat is combinational: Stat = (W_stat==BUB) ? AOK : W_stat.
- cycle_count increments by 1 on every rising edge where halted is low before the edge. The edge that loads an exception still counts. It wraps modulo 2^64.
- retired_count increments on every load whose captured m_stat==AOK. Bubbles (m_stat=0) and exceptions do not count. It wraps modulo 2^64.
- Simultaneous W_stall and exception in M: the stall wins and nothing is captured; the exception is captured on the first non-stalled edge.
- Output mapping: W_dstE, W_valE, W_dstM and W_valM map directly onto the register-file write ports. When both address the same register, port M has priority; that priority is enforced in the register file, not here.

## Timing
- M -> W latency: 1 cycle. Values present before edge N appear on the W outputs after edge N.
- All W outputs are registered with no combinational path from inputs. Stat and halted are combinational from W_stat only.
- Counters are registered and reflect the edge just taken.
- Reset asserted mid-operation: all outputs take their reset values without a clock edge. The first load happens on the first rising edge after reset deasserts.

## Test plan
- Reset, then one AOK load with M_icode=6, M_dstE=3, M_valE=0x2A, M_dstM=F, m_stat=1 -> after one edge W_dstE=3, W_valE=0x2A, retired_count=1, cycle_count=1, Stat=1.
- Assert W_stall=1 for 3 edges while M changes -> W fields unchanged, retired_count unchanged, cycle_count +3.
- Load mrmovq with M_dstM=5, m_valM=0xFF, m_stat=3 (ADR) -> W_dstM=F, W_dstE=F, Stat=3, halted=1. Further edges with AOK inputs change nothing; cycle_count stops.
- Load halt with m_stat=2 -> Stat=2, halted=1, retired_count not incremented. Async reset pulse mid-cycle -> W_stat=0, Stat=1, counters 0 immediately.
- Bubble load (m_stat=0, M_icode=1) -> Stat=1, halted=0, retired_count unchanged.
- Preload retired_count near 2^64-1 via 2^64-1 forced value (or a backdoor) -> next AOK retire wraps it to 0.
